regfile_wb_scheduler: RTL and testbench
=======================================

// Module: regfile_wb_scheduler
// PURPOSE
//  Schedules the register file's single write port between two writeback sources: ALU and load/store unit (LSU).
//  Keeps a per-register busy scoreboard and stalls issue on RAW/WAW hazards.
//  Sits between execute/memory stages and the register file; drives its w_en/rd/w_data.
//  Round-robin arbitration; one registered write per cycle.
// PARAMETERS
//  XLEN  32  data width of writeback and register file
//  AW    5   register index width; NREG = 2**AW (x0 hardwired zero)
// PORTS
//  clk        in   1     clock; all state updates on posedge
//  rst_n      in   1     asynchronous reset, active-low
//  iss_valid  in   1     decoder presents an instruction
//  iss_wb     in   1     instruction writes a destination register
//  iss_rd     in   AW    destination index
//  iss_rs1    in   AW    source 1 index
//  iss_rs2    in   AW    source 2 index
//  iss_stall  out  1     hazard; instruction must be held
//  alu_valid  in   1     ALU writeback request
//  alu_rd     in   AW    ALU destination
//  alu_data   in   XLEN  ALU result
//  alu_ready  out  1     ALU request accepted this cycle
//  lsu_valid  in   1     LSU writeback request
//  lsu_rd     in   AW    LSU destination
//  lsu_data   in   XLEN  load result
//  lsu_ready  out  1     LSU request accepted this cycle
//  rf_w_en    out  1     register file write enable
//  rf_rd      out  AW    register file write index
//  rf_w_data  out  XLEN  register file write data
//  busy_cnt   out  AW+1  number of busy registers
//  wb_err     out  1     sticky: writeback to a non-busy register
// BEHAVIOUR
//  Reset (rst_n low, async): all outputs 0.
//   - busy[] = 0; last_grant = LSU, so ALU wins first tie.
//   - Reset mid-transfer drops the pending write; rf_w_en falls immediately.
//  Issue:
//   - iss_stall = iss_valid & (busy[rs1] | busy[rs2] | (iss_wb & busy[rd])). Combinational.
//   - busy[0] is always 0.
//   - Accept = iss_valid & ~iss_stall. If also iss_wb & iss_rd!=0, set busy[iss_rd] at the edge.
//  Arbitration (combinational grant, one per cycle):
//   - Only one valid: grant it.
//   - Both valid: grant the source not in last_grant.
//   - last_grant updates only on a grant.
//   - alu_ready/lsu_ready = grant; a transfer occurs when valid & ready.
//   - Losing source holds valid/rd/data stable until granted.
//  Write stage (1-cycle latency):
//   - A transfer at edge N registers rd/data. rf_w_en=1 during cycle N+1 when rd!=0.
//   - rd==0 transfers are accepted and discarded.
//   - busy[rf_rd] clears at the edge ending the rf_w_en cycle, the same edge the regfile writes.
//   - No grant: rf_w_en=0 next cycle; rf_rd and rf_w_data hold.
//  Simultaneous events:
//   - Set and clear of the same index on one edge: set wins.
//   - A busy source stalls even during its rf_w_en cycle (regfile reads are async, pre-write).
//  Error and count:
//   - Transfer with rd!=0 and busy[rd]==0 sets wb_err, which holds until reset; the write still occurs.
//   - busy_cnt = popcount(busy), registered, range 0..NREG-1, updated same edge as busy[].
// CONFIGURATION
//  RF_WB_BYPASS_EN defined:
//   - busy[rs] with rf_w_en & rf_rd==rs does not stall.
//   - Extra outputs fwd1_en/fwd2_en (1b each) and fwd_data (XLEN, = rf_w_data); execute muxes fwd_data in.
//  RF_WB_BYPASS_EN undefined: no fwd_* ports; stall rule exactly as above.
// TESTING
//  1. Reset, issue rd=5 -> busy_cnt=1. Issue rs1=5 -> iss_stall=1.
//     ALU wb rd=5 data=0xDEADBEEF -> rf_w_en next cycle, rf_rd=5. Stall drops the cycle after rf_w_en.
//  2. Busy x3 and x4. ALU(rd=3) and LSU(rd=4) valid same cycle -> ALU granted first, LSU next cycle.
//     Two consecutive rf_w_en pulses.
//  3. Both sources continuously valid for 6 cycles -> grants alternate ALU,LSU,ALU,...; no source is granted twice in a row.
//  4. Issue rd=0 -> busy_cnt stays 0. LSU wb rd=0 -> lsu_ready=1, rf_w_en stays 0.
//  5. ALU wb rd=7 with busy[7]=0 -> wb_err=1 and write occurs. wb_err stays 1 until rst_n low.
//  6. rst_n low while rf_w_en=1 -> rf_w_en, busy_cnt, wb_err 0 without a clock edge.
//     With RF_WB_BYPASS_EN: rs1 = rf_rd in the rf_w_en cycle -> no stall, fwd1_en=1.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
//   Shares the register file's single write port between the ALU and LSU
//   writeback sources with round-robin arbitration, and tracks a per-register
//   busy scoreboard that stalls issue on RAW/WAW hazards.
// Ports
//   clk, rst_n                     clock, async active-low reset
//   iss_valid/wb/rd/rs1/rs2        decoder issue request
//   iss_stall                      combinational hazard stall
//   alu_valid/rd/data, alu_ready   ALU writeback handshake
//   lsu_valid/rd/data, lsu_ready   LSU writeback handshake
//   rf_w_en/rf_rd/rf_w_data        registered register-file write port
//   busy_cnt                       registered popcount of busy registers
//   wb_err                         sticky: writeback to a non-busy register
// Configuration
//   RF_WB_BYPASS_EN: a source being written this cycle does not stall; adds
//   fwd1_en/fwd2_en/fwd_data so execute can take the write data directly.
module regfile_wb_scheduler #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic            iss_wb,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  output logic            iss_stall,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            rf_w_en,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_w_data,
  output logic [AW:0]     busy_cnt,
  output logic            wb_err
`ifdef RF_WB_BYPASS_EN
  ,
  output logic            fwd1_en,
  output logic            fwd2_en,
  output logic [XLEN-1:0] fwd_data
`endif
);

  localparam int unsigned NREG = 2 ** AW;
  localparam int unsigned CW   = AW + 1;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LSU = 1'b1
  } grant_e;

  grant_e            last_q, last_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rf_w_en_q, rf_w_en_d;
  logic [AW-1:0]     rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]   rf_w_data_q, rf_w_data_d;
  logic              wb_err_q, wb_err_d;

  logic              grant_alu, grant_lsu, xfer;
  logic [AW-1:0]     xfer_rd;
  logic [XLEN-1:0]   xfer_data;
  logic              hz1, hz2, hz_rd, iss_accept;

  // Source hazards; with bypass, a register written this cycle is forwarded
`ifdef RF_WB_BYPASS_EN
  logic hit1, hit2;
  assign hit1     = rf_w_en_q & (rf_rd_q == iss_rs1);
  assign hit2     = rf_w_en_q & (rf_rd_q == iss_rs2);
  assign hz1      = busy_q[iss_rs1] & ~hit1;
  assign hz2      = busy_q[iss_rs2] & ~hit2;
  assign fwd1_en  = hit1;
  assign fwd2_en  = hit2;
  assign fwd_data = rf_w_data_q;
`else
  assign hz1 = busy_q[iss_rs1];
  assign hz2 = busy_q[iss_rs2];
`endif

  assign hz_rd      = iss_wb & busy_q[iss_rd];
  assign iss_stall  = iss_valid & (hz1 | hz2 | hz_rd);
  assign iss_accept = iss_valid & ~iss_stall;

  // Round-robin: on a tie the source not granted last time wins
  assign grant_alu = alu_valid & (~lsu_valid | (last_q == GNT_LSU));
  assign grant_lsu = lsu_valid & ~grant_alu;
  assign alu_ready = grant_alu;
  assign lsu_ready = grant_lsu;
  assign xfer      = grant_alu | grant_lsu;
  assign xfer_rd   = grant_alu ? alu_rd   : lsu_rd;
  assign xfer_data = grant_alu ? alu_data : lsu_data;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= GNT_LSU;
      busy_q      <= '0;
      cnt_q       <= '0;
      rf_w_en_q   <= 1'b0;
      rf_rd_q     <= '0;
      rf_w_data_q <= '0;
      wb_err_q    <= 1'b0;
    end else begin
      last_q      <= last_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      rf_w_en_q   <= rf_w_en_d;
      rf_rd_q     <= rf_rd_d;
      rf_w_data_q <= rf_w_data_d;
      wb_err_q    <= wb_err_d;
    end
  end

  // Next state: write stage, scoreboard update, error and count
  always_comb begin
    last_d      = last_q;
    busy_d      = busy_q;
    rf_w_en_d   = 1'b0;
    rf_rd_d     = rf_rd_q;
    rf_w_data_d = rf_w_data_q;
    wb_err_d    = wb_err_q;
    cnt_d       = '0;

    if (xfer) begin
      last_d = grant_alu ? GNT_ALU : GNT_LSU;
    end

    // rd==0 transfers complete the handshake but never reach the regfile
    if (xfer && (xfer_rd != '0)) begin
      rf_w_en_d   = 1'b1;
      rf_rd_d     = xfer_rd;
      rf_w_data_d = xfer_data;
      if (!busy_q[xfer_rd]) begin
        wb_err_d = 1'b1;
      end
    end

    // Clear first so a same-edge set of the same index wins
    if (rf_w_en_q) begin
      busy_d[rf_rd_q] = 1'b0;
    end
    if (iss_accept && iss_wb && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;

    for (int i = 0; i < NREG; i++) begin
      cnt_d = cnt_d + CW'(busy_d[i]);
    end
  end

  assign rf_w_en   = rf_w_en_q;
  assign rf_rd     = rf_rd_q;
  assign rf_w_data = rf_w_data_q;
  assign busy_cnt  = cnt_q;
  assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Testbench for regfile_wb_scheduler: directed scenarios plus a randomized
// phase, every cycle compared against a scoreboard model of the write port.
module tb_regfile_wb_scheduler;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  logic            clk, rst_n;
  logic            iss_valid, iss_wb;
  logic [AW-1:0]   iss_rd, iss_rs1, iss_rs2;
  logic            iss_stall;
  logic            alu_valid, alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid, lsu_ready;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            rf_w_en;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_w_data;
  logic [AW:0]     busy_cnt;
  logic            wb_err;
`ifdef RF_WB_BYPASS_EN
  logic            fwd1_en, fwd2_en;
  logic [XLEN-1:0] fwd_data;
`endif

  regfile_wb_scheduler #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_wb(iss_wb), .iss_rd(iss_rd),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_stall(iss_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_w_en(rf_w_en), .rf_rd(rf_rd), .rf_w_data(rf_w_data),
    .busy_cnt(busy_cnt), .wb_err(wb_err)
`ifdef RF_WB_BYPASS_EN
    , .fwd1_en(fwd1_en), .fwd2_en(fwd2_en), .fwd_data(fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_busy [32];
  bit          m_last_alu;
  bit          m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          m_err;

  // DUT combinational samples and model grants from the latest step
  logic s_stall, s_alu_ready, s_lsu_ready, s_fwd1;
  bit   s_g_alu, s_g_lsu;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_last_alu = 1'b0;
    m_wen = 1'b0; m_rd = '0; m_data = '0; m_err = 1'b0;
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_wb = 0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs
  task automatic step();
    bit e_stall, ga, gl, h1, h2, n_wen;
    logic [4:0]  n_rd, trd;
    logic [31:0] n_data, tdata;
    @(negedge clk);
    h1 = m_busy[iss_rs1];
    h2 = m_busy[iss_rs2];
`ifdef RF_WB_BYPASS_EN
    if (m_wen && m_rd == iss_rs1) h1 = 1'b0;
    if (m_wen && m_rd == iss_rs2) h2 = 1'b0;
    check("fwd1_en", fwd1_en, m_wen && m_rd == iss_rs1);
    check("fwd2_en", fwd2_en, m_wen && m_rd == iss_rs2);
    check("fwd_data", fwd_data, m_data);
    s_fwd1 = fwd1_en;
`else
    s_fwd1 = 1'b0;
`endif
    e_stall = iss_valid && (h1 || h2 || (iss_wb && m_busy[iss_rd]));
    if (alu_valid && lsu_valid) begin
      ga = !m_last_alu; gl = m_last_alu;
    end else begin
      ga = alu_valid; gl = lsu_valid;
    end
    s_stall = iss_stall; s_alu_ready = alu_ready; s_lsu_ready = lsu_ready;
    check("iss_stall", iss_stall, e_stall);
    check("alu_ready", alu_ready, ga);
    check("lsu_ready", lsu_ready, gl);
    s_g_alu = ga; s_g_lsu = gl;

    n_wen = 1'b0; n_rd = m_rd; n_data = m_data;
    if (ga || gl) begin
      m_last_alu = ga;
      trd   = ga ? alu_rd : lsu_rd;
      tdata = ga ? alu_data : lsu_data;
      if (trd != 0) begin
        n_wen = 1'b1; n_rd = trd; n_data = tdata;
        if (!m_busy[trd]) m_err = 1'b1;
      end
    end
    if (m_wen) m_busy[m_rd] = 1'b0;
    if (iss_valid && !e_stall && iss_wb && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    m_wen = n_wen; m_rd = n_rd; m_data = n_data;

    @(posedge clk); #1;
    check("rf_w_en", rf_w_en, m_wen);
    check("rf_rd", rf_rd, m_rd);
    check("rf_w_data", rf_w_data, m_data);
    check("busy_cnt", busy_cnt, m_count());
    check("wb_err", wb_err, m_err);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_w_en", rf_w_en, 0);
    check("rst_busy_cnt", busy_cnt, 0);
    check("rst_wb_err", wb_err, 0);
    check("rst_rf_rd", rf_rd, 0);
    check("rst_rf_w_data", rf_w_data, 0);
    m_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    m_reset();
    #12;
    do_reset();

    // Test 1: RAW stall on x5 until the cycle after its write
    iss_valid = 1; iss_wb = 1; iss_rd = 5; iss_rs1 = 0; iss_rs2 = 0;
    step();
    check("t1_busy_cnt", busy_cnt, 1);
    iss_wb = 0; iss_rd = 0; iss_rs1 = 5;
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 0;
    check("t1_stall", s_stall, 1);
    check("t1_wen", rf_w_en, 1);
    check("t1_rd", rf_rd, 5);
    check("t1_data", rf_w_data, 32'hDEADBEEF);
    step();
    check("t1_stall_during_wen", s_stall, 1);
    step();
    check("t1_stall_dropped", s_stall, 0);
    iss_valid = 0; iss_rs1 = 0;

    // Test 2: simultaneous requests after reset, ALU then LSU
    do_reset();
    iss_valid = 1; iss_wb = 1; iss_rd = 3; step();
    iss_rd = 4; step();
    idle_inputs();
    alu_valid = 1; alu_rd = 3; alu_data = 32'h3333;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h4444;
    step();
    check("t2_alu_first", s_alu_ready, 1);
    check("t2_lsu_wait", s_lsu_ready, 0);
    check("t2_wen1", rf_w_en, 1);
    check("t2_rd1", rf_rd, 3);
    alu_valid = 0;
    step();
    check("t2_lsu_second", s_lsu_ready, 1);
    check("t2_wen2", rf_w_en, 1);
    check("t2_rd2", rf_rd, 4);
    check("t2_data2", rf_w_data, 32'h4444);
    lsu_valid = 0;
    step();
    check("t2_cnt_zero", busy_cnt, 0);

    // Test 3: both continuously valid -> strict alternation
    alu_valid = 1; lsu_valid = 1; alu_rd = 0; lsu_rd = 0;
    for (int i = 0; i < 6; i++) begin
      alu_data = 32'(i); lsu_data = 32'(i + 100);
      step();
      check("t3_alu_alt", s_alu_ready, (i % 2) == 0);
      check("t3_lsu_alt", s_lsu_ready, (i % 2) == 1);
    end
    alu_valid = 0; lsu_valid = 0;

    // Test 4: rd=0 issue and rd=0 writeback are harmless
    iss_valid = 1; iss_wb = 1; iss_rd = 0;
    step();
    iss_valid = 0; iss_wb = 0;
    check("t4_cnt", busy_cnt, 0);
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h55;
    step();
    check("t4_lsu_ready", s_lsu_ready, 1);
    check("t4_no_wen", rf_w_en, 0);
    lsu_valid = 0;

    // Randomized phase: sources hold requests until granted
    for (int c = 0; c < 400; c++) begin
      iss_valid = 1'($urandom_range(0, 1));
      iss_wb    = 1'($urandom_range(0, 1));
      iss_rd    = 5'($urandom_range(0, 7));
      iss_rs1   = 5'($urandom_range(0, 7));
      iss_rs2   = 5'($urandom_range(0, 7));
      if (!alu_valid && $urandom_range(0, 2) != 0) begin
        alu_valid = 1; alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
      end
      if (!lsu_valid && $urandom_range(0, 2) != 0) begin
        lsu_valid = 1; lsu_rd = 5'($urandom_range(0, 7)); lsu_data = $urandom;
      end
      step();
      if (s_g_alu) alu_valid = 0;
      if (s_g_lsu) lsu_valid = 0;
    end
    idle_inputs();
    step();

    // Test 5: writeback to a non-busy register is flagged but still written
    do_reset();
    alu_valid = 1; alu_rd = 7; alu_data = 32'hCAFE0007;
    step();
    alu_valid = 0;
    check("t5_err", wb_err, 1);
    check("t5_wen", rf_w_en, 1);
    check("t5_rd", rf_rd, 7);
    repeat (3) step();
    check("t5_err_sticky", wb_err, 1);

    // Test 6: reset while a write is in flight
    iss_valid = 1; iss_wb = 1; iss_rd = 9;
    step();
    iss_valid = 0; iss_wb = 0; iss_rd = 0;
    alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    step();
    alu_valid = 0;
    check("t6_wen_before", rf_w_en, 1);
    do_reset();

`ifdef RF_WB_BYPASS_EN
    // Bypass: source equal to the register being written does not stall
    iss_valid = 1; iss_wb = 1; iss_rd = 6;
    step();
    iss_valid = 0; iss_wb = 0; iss_rd = 0;
    alu_valid = 1; alu_rd = 6; alu_data = 32'h66;
    step();
    alu_valid = 0;
    iss_valid = 1; iss_rs1 = 6;
    step();
    check("byp_no_stall", s_stall, 0);
    check("byp_fwd1", s_fwd1, 1);
    idle_inputs();
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
